// File: rtl/pcie_tlp_tx_arbiter.sv
// pcie_tlp_tx_arbiter: round-robin arbiter serializing per-requester TLP headers and payloads
// onto one 32-bit AXI-Stream with a single output register stage.
module pcie_tlp_tx_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ*128-1:0] s_hdr,
    input  logic [NUM_REQ-1:0]     s_hdr_valid,
    output logic [NUM_REQ-1:0]     s_hdr_ready,
    input  logic [NUM_REQ*32-1:0]  s_pld_tdata,
    input  logic [NUM_REQ-1:0]     s_pld_tvalid,
    output logic [NUM_REQ-1:0]     s_pld_tready,
    input  logic [NUM_REQ-1:0]     s_pld_tlast,
    output logic [31:0]            m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   len_err
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t        state, state_n;
    logic [IW-1:0] rr_ptr, rr_n, gidx, gidx_n, win;
    logic [95:0]   hdr_q, hdr_n;
    logic          is4, is4_n, hasd, hasd_n;
    logic [10:0]   cnt, cnt_n;
    logic [1:0]    hidx, hidx_n;
    logic [31:0]   tdata_n, hw;
    logic          tvalid_n, tlast_n, tuser_n, len_err_n, slot_free, last_hdr, cnt_last;
    logic [NUM_REQ-1:0] grant_n;

    function automatic logic [IW-1:0] pick(input logic [NUM_REQ-1:0] v, input logic [IW-1:0] p);
        logic [IW-1:0] r;
        r = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (v[(int'(p) + k) % NUM_REQ]) r = IW'((int'(p) + k) % NUM_REQ);
        return r;
    endfunction

    assign win       = pick(s_hdr_valid, rr_ptr);
    assign slot_free = !m_axis_tvalid || m_axis_tready;
    assign last_hdr  = hidx == (is4 ? 2'd3 : 2'd2);
    assign cnt_last  = cnt == 11'd1;
    // DW0 is sent straight from the input at accept time, so only DW1..DW3 are stored
    assign hw = (hidx == 2'd1) ? hdr_q[95:64] : (hidx == 2'd2) ? hdr_q[63:32] : hdr_q[31:0];

    always_comb begin
        state_n      = state;
        rr_n         = rr_ptr;
        gidx_n       = gidx;
        hdr_n        = hdr_q;
        is4_n        = is4;
        hasd_n       = hasd;
        cnt_n        = cnt;
        hidx_n       = hidx;
        tdata_n      = m_axis_tdata;
        tvalid_n     = m_axis_tvalid && !m_axis_tready;
        tlast_n      = m_axis_tlast;
        tuser_n      = m_axis_tuser;
        len_err_n    = 1'b0;
        grant_n      = (m_axis_tvalid && m_axis_tready && m_axis_tlast) ? '0 : grant;
        s_hdr_ready  = '0;
        s_pld_tready = '0;
        case (state)
            IDLE: begin
                // waiting for an empty output slot yields the single bubble between TLPs
                if (!rst && !m_axis_tvalid && |s_hdr_valid) begin
                    s_hdr_ready[win] = 1'b1;
                    hdr_n    = s_hdr[int'(win)*128 +: 96];
                    is4_n    = s_hdr[int'(win)*128 + 125];
                    hasd_n   = s_hdr[int'(win)*128 + 126];
                    cnt_n    = (s_hdr[int'(win)*128 + 96 +: 10] == 10'd0) ? 11'd1024
                             : {1'b0, s_hdr[int'(win)*128 + 96 +: 10]};
                    gidx_n   = win;
                    grant_n  = NUM_REQ'(1) << win;
                    rr_n     = IW'((int'(win) + 1) % NUM_REQ);
                    tvalid_n = 1'b1;
                    tdata_n  = s_hdr[int'(win)*128 + 96 +: 32];
                    tuser_n  = 1'b1;
                    tlast_n  = 1'b0;
                    hidx_n   = 2'd1;
                    state_n  = HDR;
                end
            end
            HDR: begin
                if (slot_free) begin
                    tvalid_n = 1'b1;
                    tdata_n  = hw;
                    tuser_n  = 1'b0;
                    tlast_n  = last_hdr && !hasd;
                    hidx_n   = hidx + 2'd1;
                    if (last_hdr) state_n = hasd ? DATA : IDLE;
                end
            end
            DATA: begin
                s_pld_tready[gidx] = slot_free;
                if (slot_free && s_pld_tvalid[gidx]) begin
                    tvalid_n  = 1'b1;
                    tdata_n   = s_pld_tdata[int'(gidx)*32 +: 32];
                    tuser_n   = 1'b0;
                    tlast_n   = cnt_last;
                    len_err_n = s_pld_tlast[gidx] != cnt_last;
                    cnt_n     = cnt - 11'd1;
                    if (cnt_last) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            gidx          <= '0;
            hdr_q         <= '0;
            is4           <= 1'b0;
            hasd          <= 1'b0;
            cnt           <= '0;
            hidx          <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            grant         <= '0;
            len_err       <= 1'b0;
        end else begin
            state         <= state_n;
            rr_ptr        <= rr_n;
            gidx          <= gidx_n;
            hdr_q         <= hdr_n;
            is4           <= is4_n;
            hasd          <= hasd_n;
            cnt           <= cnt_n;
            hidx          <= hidx_n;
            m_axis_tdata  <= tdata_n;
            m_axis_tvalid <= tvalid_n;
            m_axis_tlast  <= tlast_n;
            m_axis_tuser  <= tuser_n;
            grant         <= grant_n;
            len_err       <= len_err_n;
        end
    end
endmodule

// File: tb/tb_pcie_tlp_tx_arbiter.sv
// tb_pcie_tlp_tx_arbiter: directed and randomized TLP traffic checked against a DW-list model
// built from the header fields.
module tb_pcie_tlp_tx_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*128-1:0] s_hdr = '0;
    logic [N-1:0]   s_hdr_valid = '0;
    logic [N-1:0]   s_hdr_ready;
    logic [N*32-1:0] s_pld_tdata = '0;
    logic [N-1:0]   s_pld_tvalid = '0;
    logic [N-1:0]   s_pld_tready;
    logic [N-1:0]   s_pld_tlast = '0;
    logic [31:0]    m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tready = 1'b1;
    logic           m_axis_tlast;
    logic           m_axis_tuser;
    logic [N-1:0]   grant;
    logic           len_err;

    pcie_tlp_tx_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .s_hdr(s_hdr), .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
        .s_pld_tdata(s_pld_tdata), .s_pld_tvalid(s_pld_tvalid), .s_pld_tready(s_pld_tready),
        .s_pld_tlast(s_pld_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .grant(grant), .len_err(len_err)
    );

    always #5 clk = ~clk;

    typedef logic [37:0] beat_t;
    beat_t       got[$], exp[$];
    logic [31:0] pl[$];
    bit          plast[$];
    int          checks = 0, errors = 0, lerr_cnt = 0, exp_lerr = 0, model_rr = 0;
    bit          rand_rdy = 1'b0;
    beat_t       cur, prev;
    bit          prev_v, prev_r, have_prev;

    assign cur = {grant, m_axis_tuser, m_axis_tlast, m_axis_tdata};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic logic [127:0] mkhdr(input logic [2:0] fmt, input logic [9:0] len);
        logic [127:0] h;
        h = {$urandom, $urandom, $urandom, $urandom};
        h[127:125] = fmt;
        h[105:96]  = len;
        return h;
    endfunction

    function automatic void gen_pl(input int nd, input int early);
        pl.delete();
        plast.delete();
        for (int j = 0; j < nd; j++) begin
            pl.push_back($urandom);
            plast.push_back(j == nd - 1 || j == early);
        end
    endfunction

    // expected DW list: header words, then Length payload DWs when Fmt says data
    function automatic void model(input int r, input logic [127:0] h);
        int nh, nd;
        logic [31:0] dw;
        nh = h[125] ? 4 : 3;
        nd = h[126] ? ((h[105:96] == 10'd0) ? 1024 : int'(h[105:96])) : 0;
        for (int i = 0; i < nh + nd; i++) begin
            dw = (i < nh) ? 32'(h >> (32 * (3 - i))) : pl[i - nh];
            exp.push_back({4'(1 << r), i == 0, i == nh + nd - 1, dw});
        end
        for (int j = 0; j < nd; j++)
            if (plast[j] != (j == nd - 1)) exp_lerr++;
    endfunction

    task automatic wait_rdy(input int r, input bit pld, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 3000) begin
            #1;
            ok = pld ? s_pld_tready[r] : s_hdr_ready[r];
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send(input int r, input logic [127:0] h, input int abort_at, input bit gaps);
        bit ok;
        s_hdr[r*128 +: 128] = h;
        s_hdr_valid[r] = 1'b1;
        wait_rdy(r, 1'b0, ok);
        s_hdr_valid[r] = 1'b0;
        chk($sformatf("hdr_accept_req%0d", r), 64'(ok), 64'd1);
        model_rr = (r + 1) % N;
        if (h[126]) begin
            for (int j = 0; j < pl.size(); j++) begin
                if (j == abort_at) return;
                if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
                s_pld_tdata[r*32 +: 32] = pl[j];
                s_pld_tlast[r] = plast[j];
                s_pld_tvalid[r] = 1'b1;
                wait_rdy(r, 1'b1, ok);
                s_pld_tvalid[r] = 1'b0;
                chk($sformatf("pld_accept_req%0d", r), 64'(ok), 64'd1);
                if (!ok) return;
            end
        end
    endtask

    task automatic check_tlp(input string tag);
        int n, m;
        n = 0;
        while (got.size() < exp.size() && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_count"}, 64'(got.size()), 64'(exp.size()));
        m = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int i = 0; i < m; i++) chk($sformatf("%s_beat%0d", tag, i), 64'(got[i]), 64'(exp[i]));
        chk({tag, "_len_err"}, 64'(lerr_cnt), 64'(exp_lerr));
        chk({tag, "_idle_grant"}, 64'(grant), 64'd0);
        got.delete();
        exp.delete();
        lerr_cnt = 0;
        exp_lerr = 0;
    endtask

    // output monitor: drives tready, records handshaken beats, checks stall stability
    always @(negedge clk) begin
        if (rst) have_prev = 1'b0;
        else begin
            m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (have_prev && prev_v && !prev_r) chk("stall_hold", 64'({m_axis_tvalid, cur}), 64'({1'b1, prev}));
            chk("pld_ready_owner", 64'(s_pld_tready & ~grant), 64'd0);
            if (m_axis_tvalid && m_axis_tready) got.push_back(cur);
            if (len_err) lerr_cnt++;
            prev_v = m_axis_tvalid;
            prev_r = m_axis_tready;
            prev = cur;
            have_prev = 1'b1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] h;
        logic [127:0] hs[N];
        logic [N-1:0] acc;
        int ord[$];
        int rr0, n, r, len, early;

        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, grant, len_err,
                                  s_hdr_ready, s_pld_tready}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // all four requesters at once with RR pointer 0
        rr0 = model_rr;
        for (int i = 0; i < N; i++) begin
            hs[i] = mkhdr({2'b00, 1'(i % 2)}, 10'($urandom_range(1, 8)));
            s_hdr[i*128 +: 128] = hs[i];
        end
        for (int k = 0; k < N; k++) model((rr0 + k) % N, hs[(rr0 + k) % N]);
        s_hdr_valid = '1;
        n = 0;
        while (s_hdr_valid != '0 && n < 500) begin
            #1;
            acc = s_hdr_ready & s_hdr_valid;
            @(negedge clk);
            s_hdr_valid = s_hdr_valid & ~acc;
            for (int i = 0; i < N; i++) if (acc[i]) ord.push_back(i);
            n++;
        end
        chk("rr_count", 64'(ord.size()), 64'(N));
        for (int k = 0; k < ord.size(); k++) chk($sformatf("rr_order%0d", k), 64'(ord[k]), 64'((rr0 + k) % N));
        model_rr = (rr0 + N) % N;
        check_tlp("all4");

        // single 3DW MRd from req0
        h = mkhdr(3'b000, 10'd1);
        gen_pl(0, -1);
        model(0, h);
        send(0, h, -1, 1'b0);
        check_tlp("mrd3");

        // 4DW MWr Len=4 from req2
        h = mkhdr(3'b011, 10'd4);
        gen_pl(4, -1);
        model(2, h);
        send(2, h, -1, 1'b0);
        check_tlp("mwr4dw");

        // Len=16 4DW MWr with random tready and payload gaps
        rand_rdy = 1'b1;
        h = mkhdr(3'b011, 10'd16);
        gen_pl(16, -1);
        model(1, h);
        send(1, h, -1, 1'b1);
        check_tlp("mwr16_stall");

        // randomized TLPs
        for (int t = 0; t < 8; t++) begin
            r = $urandom_range(0, N - 1);
            len = $urandom_range(1, 12);
            h = mkhdr({1'b0, 2'($urandom_range(0, 3))}, 10'(len));
            early = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            gen_pl(h[126] ? len : 0, early);
            model(r, h);
            send(r, h, -1, 1'b1);
            check_tlp($sformatf("rand%0d", t));
        end

        // Length 0 means 1024 DWs; early payload tlast at beat 5
        rand_rdy = 1'b0;
        h = mkhdr(3'b010, 10'd0);
        gen_pl(1024, 4);
        model(3, h);
        send(3, h, -1, 1'b0);
        check_tlp("len1024");

        // reset in the middle of a payload, then a clean TLP from req1
        h = mkhdr(3'b010, 10'd16);
        gen_pl(16, -1);
        send(0, h, 5, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("midreset_outputs", 64'({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, grant, len_err,
                                     s_hdr_ready, s_pld_tready}), 64'd0);
        s_pld_tvalid = '0;
        s_pld_tlast = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got.delete();
        exp.delete();
        lerr_cnt = 0;
        exp_lerr = 0;
        model_rr = 0;
        h = mkhdr(3'b000, 10'd2);
        gen_pl(0, -1);
        model(1, h);
        send(1, h, -1, 1'b0);
        check_tlp("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
